assoc_cache: RTL and testbench
==============================

# assoc_cache

Parametrised set-associative, write-through, write-allocate cache between the hart's fetch/MEM stage and word-granular external memory; successor to the fixed 1 KiB 2-way cache. Set count, associativity and line length are parameters. Replacement is NMRU generalised to N ways. Line fill is a sequenced multi-word burst, optionally critical-word-first. Byte-masked stores are merged inside the cache and written through as full words.

## Interface
- SETS, 32: number of sets; power of two ≥2.
- WAYS, 2: associativity; 1..8.
- LINE_WORDS, 4: 32-bit words per line; power of two ≥2.
- Derived: O = log2(LINE_WORDS)+2, S = log2(SETS), T = 32-O-S tag bits.
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_mem_ready  in  1  memory accepts a request this cycle.
- o_mem_addr  out  32  word-aligned memory address.
- o_mem_ren  out  1  read request; one-cycle pulse, only when i_mem_ready.
- o_mem_wen  out  1  write request; held until the cycle i_mem_ready=1.
- o_mem_wdata  out  32  full merged word to write.
- i_mem_rdata  in  32  read data, valid with i_mem_valid.
- i_mem_valid  in  1  one-cycle pulse returning the oldest outstanding read.
- o_busy  out  1  stall; combinational on a miss or write in IDLE.
- i_req_addr  in  32  request address, [1:0]=0; held stable by hart while o_busy.
- i_req_ren  in  1  read request; never with i_req_wen.
- i_req_wen  in  1  write request.
- i_req_mask  in  4  byte enables for writes.
- i_req_wdata  in  32  write data; held stable while o_busy.
- o_res_rdata  out  32  read data.

## Operation
- Address split: tag = [31:O+S], set = [O+S-1:O], word = [O-1:2].
- Storage per set: WAYS × (valid, tag, LINE_WORDS words); one MRU way index (log2 WAYS bits, 0 when WAYS=1).
- Hit: any valid way with matching tag; at most one way hits.
- Victim: lowest-index invalid way; if all valid, (MRU+1) mod WAYS.
- States: IDLE, FILL, WRITE, DONE.
- IDLE, read hit: o_res_rdata = hit word combinationally, o_busy=0, MRU ← hit way at edge.
- IDLE, read miss: o_busy=1; latch op=read, addr, victim; → FILL.
- IDLE, write (hit or miss): o_busy=1; latch op=write, addr, mask, wdata; hit → WRITE; miss → FILL.
- FILL: issue LINE_WORDS reads, one outstanding at a time; next read issued the cycle after previous i_mem_valid; each returned word written into victim way. After last word: victim tag ← tag, valid ← 1, MRU ← victim; → WRITE if op=write else DONE.
- WRITE: merged word = (line word & ~mask) | (wdata & mask) bytewise, written to cache at entry edge; o_mem_wen=1, o_mem_addr=req addr, o_mem_wdata=merged until i_mem_ready; then MRU ← way, → DONE.
- DONE: o_busy=0 for one cycle; o_res_rdata = requested word (post-merge for writes); → IDLE.
- Memory outputs zero whenever not issuing. i_mem_valid outside FILL ignored.

## Timing
- Reset: all valid=0, MRU=0, state IDLE; o_busy=0, o_mem_ren=0, o_mem_wen=0, o_mem_addr=0, o_mem_wdata=0; o_res_rdata=0 until first hit. Data/tag arrays not cleared.
- Read hit: 0-cycle latency, no stall.
- Memory with ready=1 and fixed latency L: read miss stalls LINE_WORDS×(L+1) cycles, then DONE; write hit stalls 1 cycle (WRITE) + DONE; write miss = fill + 1 + DONE.
- i_mem_ready low: reads/writes wait, no request lost.
- Reset mid-FILL/WRITE: abandon; partially filled line stays invalid; pending o_mem_wen dropped; late i_mem_valid ignored.
- WAYS=1: direct-mapped, victim = way 0.

## Configuration
- CACHE_CWF_EN defined: critical-word-first — fill starts at requested word offset, wraps mod LINE_WORDS (e.g. offset 2, 4 words: 2,3,0,1). Latency unchanged.
- Undefined: fill always in order 0..LINE_WORDS-1.

## Test plan
- Reset, read 0x0000_0104 (miss), memory returns addr-as-data, L=2 -> 4 reads at 0x100..0x10C (CWF: 0x104,0x108,0x10C,0x100), DONE rdata=0x0000_0104, repeat read hits with o_busy=0.
- Write miss 0x200, mask 4'b0011, wdata 0xAAAA_BBBB, memory word 0x1122_3344 -> fill, then o_mem_wen with wdata 0x1122_BBBB; later read hit returns 0x1122_BBBB.
- WAYS=2: fill tags A,B in set 0, read A, miss C -> B evicted; read A hits, B misses.
- i_mem_ready low 5 cycles during WRITE -> o_mem_wen held, addr/data stable, o_busy=1 throughout.
- Assert i_rst on 2nd fill word -> outputs zero, line invalid, re-read misses and refills all 4 words.
- WAYS=1, SETS=4, LINE_WORDS=8: conflicting addrs 0x000/0x080 alternate -> each access misses, 8-word fills.

Source files
------------

// File: rtl/assoc_cache.sv
// assoc_cache: parametrised set-associative, write-through, write-allocate cache
// sitting between the hart's fetch/MEM stage and word-granular external memory.
//
// Parameters: SETS (power of two >= 2), WAYS (1..8), LINE_WORDS (power of two >= 2).
// Optional feature: define CACHE_CWF_EN for critical-word-first line fills;
// without it lines are always filled in order 0..LINE_WORDS-1.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_mem_ready         memory accepts a request this cycle
//   o_mem_addr          word-aligned memory address (zero when idle)
//   o_mem_ren           one-cycle read request pulse
//   o_mem_wen           write request, held until accepted
//   o_mem_wdata         merged full word to write
//   i_mem_rdata         read data, valid with i_mem_valid
//   i_mem_valid         one-cycle pulse returning the outstanding read
//   o_busy              stall to the hart
//   i_req_addr          request address (word aligned)
//   i_req_ren/i_req_wen read / write request (mutually exclusive)
//   i_req_mask          byte enables for writes
//   i_req_wdata         write data
//   o_res_rdata         read result
module assoc_cache #(
    parameter int SETS       = 32,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_busy,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [3:0]  i_req_mask,
    input  logic [31:0] i_req_wdata,
    output logic [31:0] o_res_rdata
);

    localparam int WO = $clog2(LINE_WORDS);
    localparam int O  = WO + 2;
    localparam int S  = $clog2(SETS);
    localparam int T  = 32 - O - S;
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    // Storage; data and tags are not cleared by reset, only valid/MRU are.
    logic [31:0]     data_q  [WAYS][SETS][LINE_WORDS];
    logic [T-1:0]    tag_q   [WAYS][SETS];
    logic [WAYS-1:0] valid_q [SETS];
    logic [WW-1:0]   mru_q   [SETS];

    // Latched request / transaction context
    state_t          state_q;
    logic            op_wr_q;
    logic [31:2]     addr_q;
    logic [3:0]      mask_q;
    logic [31:0]     wdata_q;
    logic [WW-1:0]   way_q;
    logic [WO-1:0]   fill_idx_q;
    logic [WO-1:0]   fill_cnt_q;
    logic            pend_q;
    logic [31:0]     merged_q;
    logic [31:0]     res_q;

    // Request address fields
    logic [T-1:0]    req_tag;
    logic [S-1:0]    req_set;
    logic [WO-1:0]   req_word;
    logic [T-1:0]    a_tag;
    logic [S-1:0]    a_set;
    logic [WO-1:0]   a_word;
    logic            unused_addr_bits;

    assign req_tag  = i_req_addr[31:O+S];
    assign req_set  = i_req_addr[O+S-1:O];
    assign req_word = i_req_addr[O-1:2];
    assign a_tag    = addr_q[31:O+S];
    assign a_set    = addr_q[O+S-1:O];
    assign a_word   = addr_q[O-1:2];
    assign unused_addr_bits = ^i_req_addr[1:0];

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  m);
        logic [31:0] r;
        for (int unsigned b = 0; b < 4; b++)
            r[8*b +: 8] = m[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return r;
    endfunction

    // Lookup: hit detection and NMRU victim selection
    logic            hit;
    logic [WW-1:0]   hit_way;
    logic            inv_found;
    logic [WW-1:0]   inv_way;
    logic [WW-1:0]   victim;
    logic [31:0]     hit_word;
    logic [WO-1:0]   fill_start;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[req_set][w] && (tag_q[w][req_set] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[req_set][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
        hit_word = data_q[hit_way][req_set][req_word];
        if (inv_found)
            victim = inv_way;
        else if (mru_q[req_set] == WW'(WAYS - 1))
            victim = '0;
        else
            victim = mru_q[req_set] + WW'(1);
`ifdef CACHE_CWF_EN
        fill_start = req_word;
`else
        fill_start = '0;
`endif
    end

    // Data array write port: write-hit merge in IDLE, or returned fill word.
    // The requested word of a write miss is merged as it arrives, so the
    // line never holds the stale memory copy of that word.
    logic            dwe;
    logic [WW-1:0]   dwe_way;
    logic [S-1:0]    dwe_set;
    logic [WO-1:0]   dwe_word;
    logic [31:0]     dwe_data;
    logic            fill_last;

    always_comb begin
        dwe       = 1'b0;
        dwe_way   = way_q;
        dwe_set   = a_set;
        dwe_word  = fill_idx_q;
        dwe_data  = i_mem_rdata;
        fill_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req_wen && hit) begin
                    dwe      = 1'b1;
                    dwe_way  = hit_way;
                    dwe_set  = req_set;
                    dwe_word = req_word;
                    dwe_data = merge(hit_word, i_req_wdata, i_req_mask);
                end
            end
            FILL: begin
                if (pend_q && i_mem_valid) begin
                    dwe       = 1'b1;
                    fill_last = (fill_cnt_q == '1);
                    if (op_wr_q && (fill_idx_q == a_word))
                        dwe_data = merge(i_mem_rdata, wdata_q, mask_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (dwe)
                data_q[dwe_way][dwe_set][dwe_word] <= dwe_data;
            if (fill_last)
                tag_q[way_q][a_set] <= a_tag;
        end
    end

    // Memory-side and hart-side outputs
    logic mem_ren;
    assign mem_ren = (state_q == FILL) && !pend_q && i_mem_ready;

    always_comb begin
        o_mem_ren   = mem_ren;
        o_mem_wen   = (state_q == WRITE);
        o_mem_wdata = (state_q == WRITE) ? merged_q : '0;
        if (mem_ren)
            o_mem_addr = {a_tag, a_set, fill_idx_q, 2'b00};
        else if (state_q == WRITE)
            o_mem_addr = {addr_q, 2'b00};
        else
            o_mem_addr = '0;
        if (state_q == IDLE)
            o_busy = (i_req_ren && !hit) || i_req_wen;
        else
            o_busy = (state_q != DONE);
        o_res_rdata = ((state_q == IDLE) && i_req_ren && hit) ? hit_word : res_q;
    end

    // Control FSM
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            mask_q     <= '0;
            wdata_q    <= '0;
            way_q      <= '0;
            fill_idx_q <= '0;
            fill_cnt_q <= '0;
            pend_q     <= 1'b0;
            merged_q   <= '0;
            res_q      <= '0;
            for (int unsigned i = 0; i < SETS; i++) begin
                valid_q[i] <= '0;
                mru_q[i]   <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req_ren && hit) begin
                        mru_q[req_set] <= hit_way;
                        res_q          <= hit_word;
                    end else if (i_req_ren || i_req_wen) begin
                        op_wr_q    <= i_req_wen;
                        addr_q     <= i_req_addr[31:2];
                        mask_q     <= i_req_mask;
                        wdata_q    <= i_req_wdata;
                        fill_idx_q <= fill_start;
                        fill_cnt_q <= '0;
                        pend_q     <= 1'b0;
                        if (i_req_wen && hit) begin
                            way_q    <= hit_way;
                            merged_q <= dwe_data;
                            state_q  <= WRITE;
                        end else begin
                            way_q   <= victim;
                            state_q <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_ren)
                        pend_q <= 1'b1;
                    if (pend_q && i_mem_valid) begin
                        pend_q     <= 1'b0;
                        fill_idx_q <= fill_idx_q + WO'(1);
                        fill_cnt_q <= fill_cnt_q + WO'(1);
                        if (fill_idx_q == a_word) begin
                            if (op_wr_q)
                                merged_q <= dwe_data;
                            else
                                res_q <= i_mem_rdata;
                        end
                        if (fill_last) begin
                            valid_q[a_set][way_q] <= 1'b1;
                            mru_q[a_set]          <= way_q;
                            state_q               <= op_wr_q ? WRITE : DONE;
                        end
                    end
                end
                WRITE: begin
                    if (i_mem_ready) begin
                        mru_q[a_set] <= way_q;
                        res_q        <= merged_q;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache: default geometry (32 sets, 2 ways, 4 words)
// plus a direct-mapped 4-set, 8-word instance. Each instance has a simple
// memory model with a fixed 2-cycle read latency that returns the address
// as data (except word 0x200, which holds 0x1122_3344).
module tb_assoc_cache;

`ifdef CACHE_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Instance 1 (default parameters)
    logic        mready1;
    logic [31:0] a1, wd1, maddr1, mwd1, mrd1, rdata1;
    logic        ren1, wen1, busy1, mren1, mwen1, mval1;
    logic [3:0]  m1;

    // Instance 2 (direct mapped, 8-word lines)
    logic [31:0] a2, wd2, maddr2, mwd2, mrd2, rdata2;
    logic        ren2, wen2, busy2, mren2, mwen2, mval2;
    logic [3:0]  m2;

    assoc_cache dut1 (
        .i_clk(clk), .i_rst(rst), .i_mem_ready(mready1),
        .o_mem_addr(maddr1), .o_mem_ren(mren1), .o_mem_wen(mwen1), .o_mem_wdata(mwd1),
        .i_mem_rdata(mrd1), .i_mem_valid(mval1), .o_busy(busy1),
        .i_req_addr(a1), .i_req_ren(ren1), .i_req_wen(wen1), .i_req_mask(m1),
        .i_req_wdata(wd1), .o_res_rdata(rdata1)
    );

    assoc_cache #(.SETS(4), .WAYS(1), .LINE_WORDS(8)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_mem_ready(1'b1),
        .o_mem_addr(maddr2), .o_mem_ren(mren2), .o_mem_wen(mwen2), .o_mem_wdata(mwd2),
        .i_mem_rdata(mrd2), .i_mem_valid(mval2), .o_busy(busy2),
        .i_req_addr(a2), .i_req_ren(ren2), .i_req_wen(wen2), .i_req_mask(m2),
        .i_req_wdata(wd2), .o_res_rdata(rdata2)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a == 32'h0000_0200) ? 32'h1122_3344 : a;
    endfunction

    // Memory models
    int          rd_cnt1 = 0, rd_cnt2 = 0, wr_cnt1 = 0;
    logic [31:0] log1 [64];
    logic [31:0] log2 [64];
    logic [31:0] wr_a1 = '0, wr_d1 = '0;
    logic        p1 = 1'b0, p2 = 1'b0;
    logic [31:0] pa1 = '0, pa2 = '0;

    initial begin
        mval1 = 1'b0; mrd1 = '0; mval2 = 1'b0; mrd2 = '0;
    end

    always @(posedge clk) begin
        if (mren1) begin
            log1[rd_cnt1 % 64] <= maddr1;
            rd_cnt1 <= rd_cnt1 + 1;
        end
        p1    <= mren1;
        pa1   <= maddr1;
        mval1 <= p1;
        mrd1  <= p1 ? mdata(pa1) : '0;
        if (mwen1 && mready1) begin
            wr_cnt1 <= wr_cnt1 + 1;
            wr_a1   <= maddr1;
            wr_d1   <= mwd1;
        end
    end

    always @(posedge clk) begin
        if (mren2) begin
            log2[rd_cnt2 % 64] <= maddr2;
            rd_cnt2 <= rd_cnt2 + 1;
        end
        p2    <= mren2;
        pa2   <= maddr2;
        mval2 <= p2;
        mrd2  <= p2 ? mdata(pa2) : '0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One hart request; returns result word and number of stalled cycles.
    task automatic op(input int s, input logic w, input logic [31:0] a,
                      input logic [3:0] m, input logic [31:0] d,
                      output logic [31:0] rd, output int stalls);
        logic done;
        @(posedge clk); #1;
        if (s == 0) begin a1 = a; ren1 = !w; wen1 = w; m1 = m; wd1 = d; end
        else        begin a2 = a; ren2 = !w; wen2 = w; m2 = m; wd2 = d; end
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!((s == 0) ? busy1 : busy2)) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        rd = (s == 0) ? rdata1 : rdata2;
        chk("op_timeout", {31'b0, done}, 32'd1);
        @(posedge clk); #1;
        if (s == 0) begin ren1 = 1'b0; wen1 = 1'b0; end
        else        begin ren2 = 1'b0; wen2 = 1'b0; end
    endtask

    // Check fill read count and addresses since log index r0.
    task automatic chk_fill(input int s, input int r0, input logic [31:0] base,
                            input int start, input int n);
        int cnt;
        logic [31:0] got;
        cnt = (s == 0) ? rd_cnt1 : rd_cnt2;
        chk("fill_nreads", 32'(cnt - r0), 32'(n));
        for (int i = 0; i < n; i++) begin
            got = (s == 0) ? log1[(r0 + i) % 64] : log2[(r0 + i) % 64];
            chk("fill_addr", got, base + 32'(((start + i) % n) * 4));
        end
    endtask

    logic [31:0] rd;
    int          st;
    int          r0;
    logic        seen;

    initial begin
        rst = 1'b1; mready1 = 1'b1;
        a1 = '0; ren1 = 1'b0; wen1 = 1'b0; m1 = '0; wd1 = '0;
        a2 = '0; ren2 = 1'b0; wen2 = 1'b0; m2 = '0; wd2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy",  {31'b0, busy1}, 32'd0);
        chk("rst_ren",   {31'b0, mren1}, 32'd0);
        chk("rst_wen",   {31'b0, mwen1}, 32'd0);
        chk("rst_addr",  maddr1, 32'd0);
        chk("rst_wdata", mwd1, 32'd0);
        chk("rst_rdata", rdata1, 32'd0);

        // Read miss 0x104, then hits in the same line
        r0 = rd_cnt1;
        op(0, 1'b0, 32'h104, 4'h0, 32'h0, rd, st);
        chk("miss104_stall", 32'(st > 0), 32'd1);
        chk("miss104_rdata", rd, 32'h104);
        chk_fill(0, r0, 32'h100, CWF ? 1 : 0, 4);
        op(0, 1'b0, 32'h104, 4'h0, 32'h0, rd, st);
        chk("hit104_stall", 32'(st), 32'd0);
        chk("hit104_rdata", rd, 32'h104);
        op(0, 1'b0, 32'h10C, 4'h0, 32'h0, rd, st);
        chk("hit10C_stall", 32'(st), 32'd0);
        chk("hit10C_rdata", rd, 32'h10C);

        // Write miss with byte merge
        r0 = rd_cnt1;
        op(0, 1'b1, 32'h200, 4'b0011, 32'hAAAA_BBBB, rd, st);
        chk_fill(0, r0, 32'h200, 0, 4);
        chk("wmiss_done_rdata", rd, 32'h1122_BBBB);
        chk("wmiss_wr_addr", wr_a1, 32'h200);
        chk("wmiss_wr_data", wr_d1, 32'h1122_BBBB);
        op(0, 1'b0, 32'h200, 4'h0, 32'h0, rd, st);
        chk("wmiss_hit_stall", 32'(st), 32'd0);
        chk("wmiss_hit_rdata", rd, 32'h1122_BBBB);
        op(0, 1'b0, 32'h204, 4'h0, 32'h0, rd, st);
        chk("wmiss_hit204", rd, 32'h204);

        // NMRU: A=0x200, B=0x400, C=0x600 all map to set 0
        op(0, 1'b0, 32'h400, 4'h0, 32'h0, rd, st);
        chk("B_miss", 32'(st > 0), 32'd1);
        chk("B_rdata", rd, 32'h400);
        op(0, 1'b0, 32'h200, 4'h0, 32'h0, rd, st);
        chk("A_hit", 32'(st), 32'd0);
        op(0, 1'b0, 32'h600, 4'h0, 32'h0, rd, st);
        chk("C_miss", 32'(st > 0), 32'd1);
        chk("C_rdata", rd, 32'h600);
        op(0, 1'b0, 32'h200, 4'h0, 32'h0, rd, st);
        chk("A_hit2", 32'(st), 32'd0);
        chk("A_hit2_rdata", rd, 32'h1122_BBBB);
        op(0, 1'b0, 32'h400, 4'h0, 32'h0, rd, st);
        chk("B_evicted", 32'(st > 0), 32'd1);

        // Write hit with memory not ready for 5 cycles
        @(posedge clk); #1;
        a1 = 32'h204; wen1 = 1'b1; m1 = 4'b1100; wd1 = 32'hDEAD_0000; mready1 = 1'b0;
        @(negedge clk);
        chk("wr_idle_busy", {31'b0, busy1}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wr_hold_wen",   {31'b0, mwen1}, 32'd1);
            chk("wr_hold_addr",  maddr1, 32'h204);
            chk("wr_hold_wdata", mwd1, 32'hDEAD_0204);
            chk("wr_hold_busy",  {31'b0, busy1}, 32'd1);
        end
        @(posedge clk); #1 mready1 = 1'b1;
        @(negedge clk);
        chk("wr_accept_wen", {31'b0, mwen1}, 32'd1);
        @(negedge clk);
        chk("wr_done_busy",  {31'b0, busy1}, 32'd0);
        chk("wr_done_rdata", rdata1, 32'hDEAD_0204);
        chk("wr_done_wen",   {31'b0, mwen1}, 32'd0);
        chk("wr_mem_data",   wr_d1, 32'hDEAD_0204);
        @(posedge clk); #1 wen1 = 1'b0;
        op(0, 1'b0, 32'h204, 4'h0, 32'h0, rd, st);
        chk("wr_readback_stall", 32'(st), 32'd0);
        chk("wr_readback", rd, 32'hDEAD_0204);

        // Reset during the second fill word
        r0 = rd_cnt1;
        @(posedge clk); #1;
        a1 = 32'h300; ren1 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((rd_cnt1 - r0 == 1) && mren1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_fill_seen", {31'b0, seen}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; ren1 = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_busy",  {31'b0, busy1}, 32'd0);
        chk("rstmid_ren",   {31'b0, mren1}, 32'd0);
        chk("rstmid_wen",   {31'b0, mwen1}, 32'd0);
        chk("rstmid_addr",  maddr1, 32'd0);
        chk("rstmid_rdata", rdata1, 32'd0);
        repeat (8) @(posedge clk);
        r0 = rd_cnt1;
        op(0, 1'b0, 32'h300, 4'h0, 32'h0, rd, st);
        chk("rerd_miss", 32'(st > 0), 32'd1);
        chk("rerd_rdata", rd, 32'h300);
        chk_fill(0, r0, 32'h300, 0, 4);
        op(0, 1'b0, 32'h104, 4'h0, 32'h0, rd, st);
        chk("post_rst_104_miss", 32'(st > 0), 32'd1);
        chk("post_rst_104_rdata", rd, 32'h104);

        // Direct-mapped conflicts on the second instance
        for (int k = 0; k < 4; k++) begin
            logic [31:0] ad;
            ad = (k % 2 == 0) ? 32'h000 : 32'h080;
            r0 = rd_cnt2;
            op(1, 1'b0, ad, 4'h0, 32'h0, rd, st);
            chk("dm_miss", 32'(st > 0), 32'd1);
            chk("dm_rdata", rd, ad);
            chk_fill(1, r0, ad, 0, 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
